window_scheduler: RTL and testbench

//  Sequences the 3x3 filter datapath (blur/sharpen/edge core fed by a1..a9, select, threshold).

---
 rtl/window_scheduler.sv | 178 +++++++++++++++++
 tb/tb_window_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/window_scheduler.sv
// window_scheduler: turns a raster pixel stream into 3x3 windows for the filter core.
// Two line buffers hold the previous two rows. The window shifts left by one column on
// every accepted pixel. A window is presented only for interior pixels. The filter
// configuration is latched once per frame.
module window_scheduler #(
    parameter int DATA_W = 8,
    parameter int WIDTH  = 850,
    parameter int HEIGHT = 850
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_select,
    input  logic [7:0]        cfg_threshold,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic [DATA_W-1:0] a5,
    output logic [DATA_W-1:0] a6,
    output logic [DATA_W-1:0] a7,
    output logic [DATA_W-1:0] a8,
    output logic [DATA_W-1:0] a9,
    output logic [1:0]        select,
    output logic [7:0]        threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic              last_accepted_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic              frame_done_reg;
    logic [1:0]        select_reg;
    logic [7:0]        threshold_reg;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [DATA_W-1:0] lb0 [WIDTH];
    logic [DATA_W-1:0] lb1 [WIDTH];

    // Window registers, index 0..8 = a1..a9 (row-major, a5 = centre).
    logic [DATA_W-1:0] win_reg [9];
    // Incoming right-hand column: top, middle, bottom.
    logic [DATA_W-1:0] new_col [3];

    logic accept;
    logic interior;
    logic last_pixel;

    // The line buffer read must be combinational: the column it returns enters the
    // window on the same edge that accepts the pixel.
    assign new_col[0] = lb1[col_reg];
    assign new_col[1] = lb0[col_reg];
    assign new_col[2] = in_pixel;

    assign in_ready   = (state_reg == STREAM) && (!out_valid_reg || out_ready) && !last_accepted_reg;
    assign accept     = in_valid && in_ready;
    assign interior   = (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
    assign last_pixel = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    // Line buffer update: push the current column down one row. Not reset, because every
    // entry is overwritten before it can reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_reg] <= lb0[col_reg];
            lb0[col_reg] <= in_pixel;
        end
    end

    // One shift chain per window row: drop the left column and insert the new one on the right.
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        always_ff @(posedge clk) begin
            if (rst) begin
                win_reg[gi*3]     <= '0;
                win_reg[gi*3 + 1] <= '0;
                win_reg[gi*3 + 2] <= '0;
            end else if (accept) begin
                win_reg[gi*3]     <= win_reg[gi*3 + 1];
                win_reg[gi*3 + 1] <= win_reg[gi*3 + 2];
                win_reg[gi*3 + 2] <= new_col[gi];
            end
        end
    end

    // Frame FSM together with the counters, handshake state and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            col_reg           <= '0;
            row_reg           <= '0;
            last_accepted_reg <= 1'b0;
            out_valid_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            frame_done_reg    <= 1'b0;
            select_reg        <= '0;
            threshold_reg     <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg         <= STREAM;
                        select_reg        <= cfg_select;
                        threshold_reg     <= cfg_threshold;
                        busy_reg          <= 1'b1;
                        col_reg           <= '0;
                        row_reg           <= '0;
                        last_accepted_reg <= 1'b0;
                        out_valid_reg     <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        // A new window replaces any window handed off on this same edge.
                        out_valid_reg <= interior;
                        if (last_pixel) begin
                            last_accepted_reg <= 1'b1;
                        end
                        if (col_reg == COL_LAST) begin
                            col_reg <= '0;
                            if (row_reg != ROW_LAST) begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                    // The frame ends when the window of the final pixel is handed off.
                    if (last_accepted_reg && out_valid_reg && out_ready) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign a1         = win_reg[0];
    assign a2         = win_reg[1];
    assign a3         = win_reg[2];
    assign a4         = win_reg[3];
    assign a5         = win_reg[4];
    assign a6         = win_reg[5];
    assign a7         = win_reg[6];
    assign a8         = win_reg[7];
    assign a9         = win_reg[8];
    assign out_valid  = out_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign select     = select_reg;
    assign threshold  = threshold_reg;
endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler on a 5x4 image with pixel(r,c) = r*16 + c.
// The expected windows are built directly from image coordinates and compared, in order,
// at every output handshake.
module tb_window_scheduler;
    localparam int DW    = 8;
    localparam int W     = 5;
    localparam int H     = 4;
    localparam int LIMIT = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    cfg_select = 2'b00;
    logic [7:0]    cfg_threshold = 8'd0;
    logic [DW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic [1:0]    select;
    logic [7:0]    threshold;
    logic          out_valid;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    logic [71:0] exp_q [$];
    logic [71:0] win;

    assign win = {a1, a2, a3, a4, a5, a6, a7, a8, a9};

    always #5 clk = ~clk;

    window_scheduler #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_select(cfg_select),
        .cfg_threshold(cfg_threshold), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
        .a7(a7), .a8(a8), .a9(a9), .select(select), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int idx);
        return 8'((idx / W) * 16 + (idx % W));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 backpressure, 2 input bubbles, 3 start pulse mid-frame.
    // abort_after > 0 leaves the frame once that many pixels have been accepted.
    task automatic run_frame(input int mode, input int abort_after);
        int acc = 0;
        int wins = 0;
        int fd = 0;
        int cyc = 0;
        int bp_left = 0;
        bit bp_done = 1'b0;
        bit want_valid = 1'b0;
        logic [71:0] snap = '0;
        logic [71:0] w;
        logic [71:0] expw;
        logic [7:0] last_a5 = '0;

        // Every interior centre (r,c), in raster order, with its 3x3 neighbourhood.
        exp_q.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                w = '0;
                for (int i = -1; i <= 1; i++) begin
                    for (int j = -1; j <= 1; j++) begin
                        w = {w[63:0], pix((r + i) * W + (c + j))};
                    end
                end
                exp_q.push_back(w);
            end
        end

        cfg_select = 2'b10;
        cfg_threshold = 8'd100;
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("select_latched", 72'(select), 72'(2));
        chk("threshold_latched", 72'(threshold), 72'(100));
        chk("busy_stream", 72'(busy), 72'(1));

        while (cyc < LIMIT) begin
            start = 1'b0;
            cfg_select = 2'b10;
            if (mode == 3 && acc == 9) begin
                start = 1'b1;
                cfg_select = 2'b01;
            end
            in_valid = (acc < W * H) && (mode != 2 || $urandom_range(0, 1) == 1);
            in_pixel = pix(acc);
            if (mode == 1 && !bp_done && bp_left == 0 && wins == 2 && out_valid) begin
                bp_left = 5;
                snap = win;
            end
            out_ready = (bp_left == 0);
            #1;
            if (want_valid) chk("window_latency", 72'(out_valid), 72'(1));
            want_valid = 1'b0;
            if (bp_left > 0) begin
                chk("bp_in_ready", 72'(in_ready), 72'(0));
                chk("bp_hold", win, snap);
                bp_left--;
                if (bp_left == 0) bp_done = 1'b1;
            end
            if (frame_done) fd++;
            else if (fd > 0) break;
            if (out_valid && out_ready) begin
                expw = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk($sformatf("window%0d", wins), win, expw);
                last_a5 = a5;
                wins++;
            end
            if (in_valid && in_ready) begin
                want_valid = ((acc / W) >= 2) && ((acc % W) >= 2);
                acc++;
            end
            if (abort_after > 0 && acc >= abort_after) break;
            step();
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;

        if (abort_after == 0) begin
            chk("frame_in_time", 72'(cyc < LIMIT), 72'(1));
            chk("frame_done_once", 72'(fd), 72'(1));
            chk("window_count", 72'(wins), 72'((W - 2) * (H - 2)));
            chk("no_windows_left", 72'(exp_q.size()), 72'(0));
            chk("last_centre", 72'(last_a5), 72'(8'h23));
            chk("idle_busy", 72'(busy), 72'(0));
            chk("idle_in_ready", 72'(in_ready), 72'(0));
            chk("idle_out_valid", 72'(out_valid), 72'(0));
            chk("select_kept", 72'(select), 72'(2));
            $display("frame mode=%0d windows=%0d accepts=%0d cycles=%0d", mode, wins, acc, cyc);
        end else begin
            $display("frame mode=%0d aborted after %0d accepts", mode, acc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 72'(in_ready), 72'(0));
        chk({tag, "_out_valid"}, 72'(out_valid), 72'(0));
        chk({tag, "_busy"}, 72'(busy), 72'(0));
        chk({tag, "_frame_done"}, 72'(frame_done), 72'(0));
        chk({tag, "_window"}, win, 72'(0));
        chk({tag, "_select"}, 72'(select), 72'(0));
        chk({tag, "_threshold"}, 72'(threshold), 72'(0));
    endtask

    initial begin
        // Reset, then offer pixels without a start.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_pixel = 8'h55;
        step();
        step();
        check_reset_state("idle");
        $display("reset/idle done");
        in_valid = 1'b0;

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(3, 0);

        // Reset in the middle of a frame, then a clean frame.
        run_frame(0, 9);
        rst = 1'b1;
        step();
        step();
        check_reset_state("midrst");
        rst = 1'b0;
        step();
        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
